// File: rtl/sbox_cfg_loader.sv
// rtl/sbox_cfg_loader.sv - byte-serial config frame loader for the 5x4 switch box
//
// Receives SYNC + N_ENT entry bytes + XOR checksum, validates each entry into
// shadow registers and commits the shadow to cfg_bus atomically. A rejected
// frame leaves cfg_bus untouched.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   in_valid  frame byte valid
//   in_data   frame byte
//   in_ready  loader accepts a byte (low only in the COMMIT cycle)
//   cfg_bus   active config, entry k at [CW*k +: CW]
//   cfg_done  one-cycle pulse: frame committed
//   cfg_err   one-cycle pulse: frame rejected
//   err_code  1 checksum, 2 illegal route, 3 reserved bits set (valid with cfg_err)
//   busy      high from SYNC accept until the done/err pulse
module sbox_cfg_loader #(
    parameter int          N_TB  = 5,
    parameter int          N_LR  = 4,
    parameter int          CW    = 6,
    parameter logic [7:0]  SYNC  = 8'hA5,
    localparam int         N_ENT = 2*N_TB + 2*N_LR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic [N_ENT*CW-1:0] cfg_bus,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic [1:0]          err_code,
    output logic                busy
);

    localparam int CNT_W = $clog2(N_ENT);
    localparam logic [CNT_W-1:0] LAST_ENT = CNT_W'(N_ENT-1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_CHK    = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [7:0]          r_xor;
    logic [1:0]          r_code;      // sticky: first error seen in this frame
    logic [N_ENT*CW-1:0] r_shadow;
    logic [N_ENT*CW-1:0] r_cfg_bus;
    logic                r_done;
    logic                r_err;
    logic [1:0]          r_err_code;
    logic                r_busy;

    logic                w_xfer;

    // Side encoding: 0 undriven, 1/3 top/bottom (N_TB wires), 2/4 left/right
    // (N_LR wires), 5..7 do not exist. Reserved bits take priority.
    function automatic logic [1:0] entry_code(input logic [7:0] b);
        logic [31:0] idx;
        idx = 32'(b[5:3]);
        if (b[7:6] != 2'b00)
            return 2'd3;
        case (b[2:0])
            3'd0:       return 2'd0;
            3'd1, 3'd3: return (idx < 32'(N_TB)) ? 2'd0 : 2'd2;
            3'd2, 3'd4: return (idx < 32'(N_LR)) ? 2'd0 : 2'd2;
            default:    return 2'd2;
        endcase
    endfunction

    assign in_ready = (r_state != S_COMMIT);
    assign w_xfer   = in_valid && in_ready;

    assign cfg_bus  = r_cfg_bus;
    assign cfg_done = r_done;
    assign cfg_err  = r_err;
    assign err_code = r_err_code;
    assign busy     = r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_xor      <= '0;
            r_code     <= '0;
            r_shadow   <= '0;
            r_cfg_bus  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Anything other than SYNC while idle is line noise.
                    if (w_xfer && in_data == SYNC) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                        r_xor   <= '0;
                        r_code  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // A SYNC value here is ordinary entry data.
                    if (w_xfer) begin
                        r_shadow[CW*r_cnt +: CW] <= in_data[CW-1:0];
                        r_xor <= r_xor ^ in_data;
                        if (r_code == 2'd0)
                            r_code <= entry_code(in_data);
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_ENT)
                            r_state <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (w_xfer) begin
                        // Entry errors outrank a checksum mismatch.
                        if (r_code == 2'd0 && in_data != r_xor)
                            r_code <= 2'd1;
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (r_code == 2'd0) begin
                        r_cfg_bus  <= r_shadow;
                        r_done     <= 1'b1;
                        r_err_code <= 2'd0;
                    end else begin
                        r_err      <= 1'b1;
                        r_err_code <= r_code;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_cfg_loader.sv
// tb/tb_sbox_cfg_loader.sv - directed scoreboard bench for sbox_cfg_loader
module tb_sbox_cfg_loader;

    localparam int N_ENT = 18;
    localparam int CW    = 6;
    localparam int BW    = N_ENT*CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic [BW-1:0] cfg_bus;
    logic          cfg_done;
    logic          cfg_err;
    logic [1:0]    err_code;
    logic          busy;

    always #5 clk = ~clk;

    sbox_cfg_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .cfg_bus  (cfg_bus),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
        .err_code (err_code),
        .busy     (busy)
    );

    typedef struct {
        logic          is_err;
        logic [1:0]    code;
        logic [BW-1:0] bus;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    logic [7:0]    fr[N_ENT];
    logic [7:0]    fr_chk;
    logic [BW-1:0] cur_bus = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] frame_xor();
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < N_ENT; k++) x = x ^ fr[k];
        return x;
    endfunction

    function automatic logic [1:0] model_code();
        logic [1:0] rc;
        logic [2:0] idx;
        rc = 2'd0;
        for (int k = 0; k < N_ENT; k++) begin
            idx = fr[k][5:3];
            if (rc == 2'd0) begin
                if (fr[k][7:6] != 2'b00) rc = 2'd3;
                else if (fr[k][2:0] == 3'd1 || fr[k][2:0] == 3'd3) rc = (idx <= 3'd4) ? 2'd0 : 2'd2;
                else if (fr[k][2:0] == 3'd2 || fr[k][2:0] == 3'd4) rc = (idx <= 3'd3) ? 2'd0 : 2'd2;
                else if (fr[k][2:0] != 3'd0) rc = 2'd2;
            end
        end
        if (rc == 2'd0 && fr_chk != frame_xor()) rc = 2'd1;
        return rc;
    endfunction

    function automatic logic [BW-1:0] model_bus();
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < N_ENT; k++) b[CW*k +: CW] = fr[k][5:0];
        return b;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gaps);
        int n;
        repeat (gaps) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_frame(input string tag, input int max_gap, input bit garbage);
        exp_t e;
        exp_t got;
        int   n;
        logic rdy_commit;
        e.code   = model_code();
        e.is_err = (e.code != 2'd0);
        e.bus    = e.is_err ? cur_bus : model_bus();
        cur_bus  = e.bus;
        sb.push_back(e);

        if (garbage) begin
            send_byte(8'h00, $urandom_range(0, max_gap));
            send_byte(8'h5A, $urandom_range(0, max_gap));
            check({tag, "_busy_garbage"}, busy, 0);
        end
        send_byte(8'hA5, $urandom_range(0, max_gap));
        check({tag, "_busy_sync"}, busy, 1);
        for (int k = 0; k < N_ENT; k++) send_byte(fr[k], $urandom_range(0, max_gap));
        send_byte(fr_chk, 0);

        n = 0;
        rdy_commit = 1'bx;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) rdy_commit = in_ready;
            if (cfg_done || cfg_err) break;
        end
        check({tag, "_latency"}, n, 2);
        check({tag, "_ready_commit"}, rdy_commit, 0);

        got = sb.pop_front();
        check({tag, "_done"}, cfg_done, !got.is_err);
        check({tag, "_err"}, cfg_err, got.is_err);
        if (got.is_err) check({tag, "_code"}, err_code, got.code);
        check({tag, "_bus"}, cfg_bus, got.bus);
        check({tag, "_busy_end"}, busy, 0);
        @(negedge clk);
        check({tag, "_pulse_len"}, {cfg_done, cfg_err}, 2'b00);
        check({tag, "_bus_hold"}, cfg_bus, got.bus);
    endtask

    initial begin
        // 1: reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_bus", cfg_bus, 0);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_pulses", {cfg_done, cfg_err}, 2'b00);
        check("rst_code", err_code, 0);

        // 2: all entries bottom1, checksum 0
        for (int k = 0; k < N_ENT; k++) fr[k] = 8'h0B;
        fr_chk = 8'h00;
        send_frame("good_all0b", 0, 0);

        // 3: entry 5 illegal route, bus held
        fr[5]  = 8'h2A;
        fr_chk = frame_xor();
        send_frame("illegal_route", 0, 0);

        // 4a: valid entries, checksum flipped
        for (int k = 0; k < N_ENT; k++) fr[k] = 8'h0B;
        fr_chk = ~frame_xor();
        send_frame("bad_chk", 0, 0);

        // 4b: reserved bits set at entry 0
        fr[0]  = 8'h41;
        fr_chk = frame_xor();
        send_frame("reserved", 0, 0);

        // 5: boundary routes with gaps and leading garbage
        for (int k = 0; k < N_ENT; k++) fr[k] = 8'h00;
        fr[0]  = {2'b00, 3'd4, 3'd1};
        fr[6]  = {2'b00, 3'd4, 3'd3};
        fr[10] = {2'b00, 3'd3, 3'd2};
        fr[17] = {2'b00, 3'd3, 3'd4};
        fr[3]  = {2'b00, 3'd7, 3'd0};
        fr[12] = {2'b00, 3'd2, 3'd2};
        fr_chk = frame_xor();
        send_frame("gappy_good", 2, 1);

        // idx just past the left/right boundary
        fr[10] = {2'b00, 3'd4, 3'd2};
        fr_chk = frame_xor();
        send_frame("lr_idx4", 1, 0);

        // 6: reset mid-frame then a new good frame
        send_byte(8'hA5, 0);
        for (int k = 0; k < 9; k++) send_byte(8'h0B, 0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cur_bus = '0;
        check("midrst_bus", cfg_bus, 0);
        check("midrst_busy", busy, 0);
        for (int k = 0; k < N_ENT; k++) fr[k] = {2'b00, 3'(k % 4), 3'(1 + (k % 4))};
        fr_chk = frame_xor();
        send_frame("after_rst", 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
